accel_exec_unit: RTL and testbench

Multi-cycle execution engine for the configurable accelerator peripheral. It sits directly downstream of the register file that holds operands A–D and the opcode: on a start pulse it captures those values, runs the selected operation, and returns a 16-bit result plus status flags for the register file to latch into its result register. Multiply, multiply-accumulate and divide are iterative (one bit per cycle). Logic and add/sub operations complete in one iteration.

---
 rtl/accel_exec_unit.sv | 193 +++++++++++++++++++
 tb/tb_accel_exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/accel_exec_unit.sv
// Multi-cycle execution engine: captures op/operands on start, runs one of
// add/sub/logic/mul/mac/div, and returns a registered 16-bit result with {err, zero, carry}.
module accel_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  input  logic [7:0]  d,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_MAC = 4'h6;
  localparam logic [3:0] OP_DIV = 4'h7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  op_q;
  logic [7:0]  a_q, b_q, c_q, d_q;
  logic [3:0]  cnt_q;
  logic [16:0] acc_q, acc_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  quo_q, quo_d;
  logic        busy_q, done_q;
  logic [15:0] result_q;
  logic [2:0]  flags_q;

  logic [2:0]  step_s;
  logic [7:0]  mcand_s;
  logic        mbit_s;
  logic [16:0] addend_s;
  logic [8:0]  rem_shift_s, diff_s, sum_s;
  logic [15:0] res_s;
  logic        err_s, carry_s, last_s;
  logic [2:0]  flags_d;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

  // Datapath for one iteration plus the completion value for the captured op
  always_comb begin
    step_s = cnt_q[2:0];
    // Steps 8..15 of MAC switch the multiplier pair from a*b to c*d
    if (cnt_q[3]) begin
      mcand_s = c_q;
      mbit_s  = d_q[step_s];
    end else begin
      mcand_s = a_q;
      mbit_s  = b_q[step_s];
    end
    addend_s = {9'd0, mcand_s} << step_s;
    if (mbit_s) begin
      acc_d = acc_q + addend_s;
    end else begin
      acc_d = acc_q;
    end

    // Restoring division: dividend bits enter from quo_q MSB, quotient bits shift in at LSB
    rem_shift_s = {rem_q, quo_q[7]};
    diff_s      = rem_shift_s - {1'b0, b_q};
    if (diff_s[8]) begin
      rem_d = rem_shift_s[7:0];
      quo_d = {quo_q[6:0], 1'b0};
    end else begin
      rem_d = diff_s[7:0];
      quo_d = {quo_q[6:0], 1'b1};
    end

    sum_s   = {1'b0, a_q} + {1'b0, b_q};
    res_s   = 16'h0000;
    err_s   = 1'b0;
    carry_s = 1'b0;
    last_s  = 1'b1;
    case (op_q)
      OP_ADD: begin
        res_s   = {7'd0, sum_s};
        carry_s = sum_s[8];
      end
      OP_SUB: begin
        res_s   = {8'h00, a_q - b_q};
        carry_s = (a_q < b_q);
      end
      OP_AND: res_s = {8'h00, a_q & b_q};
      OP_OR:  res_s = {8'h00, a_q | b_q};
      OP_XOR: res_s = {8'h00, a_q ^ b_q};
      OP_MUL: begin
        res_s  = acc_d[15:0];
        last_s = (cnt_q == 4'd7);
      end
      OP_MAC: begin
        res_s   = acc_d[15:0];
        carry_s = acc_d[16];
        last_s  = (cnt_q == 4'd15);
      end
      OP_DIV: begin
        if (b_q == 8'd0) begin
          res_s = {a_q, 8'hFF};
          err_s = 1'b1;
        end else begin
          res_s  = {rem_d, quo_d};
          last_s = (cnt_q == 4'd7);
        end
      end
      default: begin
        res_s = 16'h0000;
        err_s = 1'b1;
      end
    endcase
    flags_d = {err_s, (res_s == 16'h0000), carry_s};
  end

  // Control FSM with capture, iteration state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 4'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 8'h00;
      d_q      <= 8'h00;
      cnt_q    <= 4'd0;
      acc_q    <= 17'd0;
      rem_q    <= 8'h00;
      quo_q    <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            d_q     <= d;
            cnt_q   <= 4'd0;
            acc_q   <= 17'd0;
            rem_q   <= 8'h00;
            quo_q   <= a;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        EXEC: begin
          if (last_s) begin
            result_q <= res_s;
            flags_q  <= flags_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q   <= cnt_q + 4'd1;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_exec_unit.sv
// Self-checking bench for accel_exec_unit: directed cases plus randomized ops
// compared against an arithmetic reference model (value, flags and latency).
module tb_accel_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  a, b, c, d;
  logic        busy, done;
  logic [15:0] result;
  logic [2:0]  flags;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_res;
  logic [2:0]  prev_flags;

  always #5 clk = ~clk;

  accel_exec_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: result/flags from plain arithmetic, n = edges from T+1 to completion
  function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] z, input logic [7:0] w,
                                output logic [15:0] r, output logic [2:0] f, output int n);
    int   s;
    logic err, cy;
    err = 1'b0;
    cy  = 1'b0;
    n   = 1;
    s   = 0;
    case (o)
      4'h0: begin s = x + y; r = s[15:0]; cy = (s > 255); end
      4'h1: begin s = x - y; r = {8'h00, s[7:0]}; cy = (x < y); end
      4'h2: r = {8'h00, x & y};
      4'h3: r = {8'h00, x | y};
      4'h4: r = {8'h00, x ^ y};
      4'h5: begin s = x * y; r = s[15:0]; n = 8; end
      4'h6: begin s = x * y + z * w; r = s[15:0]; cy = (s > 65535); n = 16; end
      4'h7: begin
        if (y == 8'd0) begin
          r   = {x, 8'hFF};
          err = 1'b1;
        end else begin
          r = {x % y, x / y};
          n = 8;
        end
      end
      default: begin r = 16'h0000; err = 1'b1; end
    endcase
    f = {err, (r == 16'h0000), cy};
  endfunction

  // Called at a negedge; issues one op and checks it cycle by cycle to completion
  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z, input logic [7:0] w,
                        input bit disturb, input bit noisy);
    logic [15:0] er;
    logic [2:0]  ef;
    int          n;
    model(o, x, y, z, w, er, ef, n);
    op = o; a = x; b = y; c = z; d = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("issue_busy_done", {30'd0, busy, done}, 32'd2);
    for (int j = 0; j < n; j++) begin
      if (noisy) begin
        start = 1'($urandom);
        op = 4'($urandom);
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      end
      if (disturb) begin
        if (j == 2) begin op = 4'h2; a = 8'h01; b = 8'h02; end
        if (j == 3) start = 1'b1;
        if (j == 4) start = 1'b0;
      end
      @(negedge clk);
      if (j + 1 < n) begin
        check_eq("exec_hold", {11'd0, busy, done, flags, result},
                 {11'd0, 1'b1, 1'b0, prev_flags, prev_res});
      end else begin
        check_eq("done_busy", {30'd0, busy, done}, 32'd1);
        check_eq("result", {16'd0, result}, {16'd0, er});
        check_eq("flags", {29'd0, flags}, {29'd0, ef});
      end
    end
    start = 1'b0;
    prev_res   = er;
    prev_flags = ef;
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; op = 4'h0;
    a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
    prev_res = 16'h0000; prev_flags = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", {10'd0, busy, done, flags, result}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'h0, 8'd200, 8'd100, 8'd0, 8'd0, 1'b0, 1'b0);
    check_eq("tp_add", {13'd0, flags, result}, {13'd0, 3'b001, 16'h012C});
    @(negedge clk);
    check_eq("done_one_cycle", {30'd0, busy, done}, 32'd0);

    run_op(4'h5, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    check_eq("tp_mul", {16'd0, result}, {16'd0, 16'hFE01});
    @(negedge clk);
    check_eq("mul_late_start_ignored", {30'd0, busy, done}, 32'd0);

    run_op(4'h6, 8'd200, 8'd100, 8'd200, 8'd100, 1'b0, 1'b0);
    run_op(4'h6, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0);
    check_eq("tp_mac_carry", {13'd0, flags, result}, {13'd0, 3'b001, 16'hFC02});
    run_op(4'h7, 8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
    run_op(4'h7, 8'h55, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0);
    check_eq("tp_div0", {13'd0, flags, result}, {13'd0, 3'b100, 16'h55FF});

    // Illegal op followed by SUB issued in the done cycle
    run_op(4'hA, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b0);
    run_op(4'h1, 8'd5, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0);
    check_eq("tp_sub_b2b", {13'd0, flags, result}, {13'd0, 3'b001, 16'h00FC});

    // Reset at edge T+4 of a MUL
    @(negedge clk);
    op = 4'h5; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_exec", {10'd0, busy, done, flags, result}, 32'd0);
    rst = 1'b0;
    prev_res = 16'h0000; prev_flags = 3'b000;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_eq("no_done_after_abort", done_seen, 32'd0);
    run_op(4'h4, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0);
    check_eq("tp_xor", {16'd0, result}, {16'd0, 16'h00CC});

    for (int i = 0; i < 60; i++) begin
      logic [3:0] ro;
      logic [7:0] rb;
      ro = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(ro, 8'($urandom), rb, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
